// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// -----------------------------------------------------------------------------
// Shared definitions for the runtime-configurable clock divider.
//
// Contents:
//   state_t          controller state encoding (STOP, RUN, PENDING)
//   MIN_DIV_DEF      default smallest legal divisor
//   DIV_DEFAULT_DEF  default divisor after reset (1 Hz from a 50 MHz clock)
//   PCNT_W           width of the optional period counter
//                    (present only when CLKDIV_CTRL_PCNT_EN is defined)
// -----------------------------------------------------------------------------
package clkdiv_pkg;

   // STOP    : counter parked at zero, q low.
   // RUN     : counting with the divisor in force.
   // PENDING : counting, a new divisor waits for the next period boundary.
   typedef enum logic [1:0] {
      STOP    = 2'd0,
      RUN     = 2'd1,
      PENDING = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV_DEF     = 2;
   localparam int unsigned DIV_DEFAULT_DEF = 50000000;
   localparam int unsigned PCNT_W          = 16;

endpackage : clkdiv_pkg

// File: rtl/clkdiv_core.sv
// -----------------------------------------------------------------------------
// clkdiv_core
// -----------------------------------------------------------------------------
// Period counter of the clock divider: counts 0 .. div-1, detects the wrap and
// produces the registered square wave q and the one-cycle tick strobe.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   div    in   N   divisor currently in force (always >= 2)
//   run    in   counting enable; low parks the counter at zero
//   clear  in   forces the counter to zero (controller is stopped)
//   q      out  divided square wave, high iff the count is in the upper half
//   tick   out  one-cycle strobe in the cycle after each wrap edge
//   wrap   out  combinational: this cycle is the last of the period and the
//               counter is advancing, i.e. the next edge is a wrap edge
// -----------------------------------------------------------------------------
module clkdiv_core #(
   parameter int N = 26
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] div,
   input  logic         run,
   input  logic         clear,
   output logic         q,
   output logic         tick,
   output logic         wrap
);

   logic [N-1:0] cnt;
   logic [N-1:0] cnt_next;
   logic         counting;
   logic         at_last;

   always_comb begin
      counting = run && !clear;
      // div >= 2 is guaranteed by the controller, so div-1 never underflows.
      at_last  = (cnt == (div - N'(1)));
      cnt_next = '0;
      if (counting && !at_last) begin
         cnt_next = cnt + N'(1);
      end
   end

   assign wrap = counting && at_last;

   // q is registered from the next count so it lines up with cnt in the same
   // cycle. After a wrap the next count is 0 and q is low for any div >= 2,
   // so a divisor swap at the boundary cannot shorten the high phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         q    <= 1'b0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         q    <= counting && (cnt_next >= (div >> 1));
         tick <= wrap;
      end
   end

endmodule : clkdiv_core

// File: rtl/clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_ctrl
// -----------------------------------------------------------------------------
// Runtime-configurable clock-divider controller. Generates the divided square
// wave q and a one-cycle tick per period; the divisor is reloaded through a
// valid/ready configuration port and only ever changes at a period boundary
// (or while stopped), so q never produces a short period.
//
// Optional feature: define CLKDIV_CTRL_PCNT_EN to add the 16-bit period_cnt
// output, which counts ticks and clears whenever div_active changes.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   en          in   run enable (level)
//   cfg_valid   in   a new divisor is presented
//   cfg_div     in   N  requested divisor
//   cfg_ready   out  controller can accept a divisor
//   cfg_err     out  one-cycle pulse: last accepted request was illegal
//   q           out  divided square wave
//   tick        out  one-cycle strobe per completed period
//   running     out  high in RUN or PENDING
//   div_active  out  N  divisor currently in force
//   period_cnt  out  16 tick counter (CLKDIV_CTRL_PCNT_EN only)
//
// Configuration handshake: a request transfers on any rising edge where
// cfg_valid && cfg_ready. The requester holds cfg_valid and cfg_div stable
// until that edge; cfg_valid is ignored while cfg_ready is low. Every
// transferred request is consumed, legal or not; an illegal one
// (cfg_div < MIN_DIV) only raises cfg_err for one cycle.
// -----------------------------------------------------------------------------
module clkdiv_ctrl
   import clkdiv_pkg::*;
#(
   parameter int          N           = 26,
   parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_DEF,
   parameter int unsigned MIN_DIV     = MIN_DIV_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              cfg_valid,
   input  logic [N-1:0]      cfg_div,
   output logic              cfg_ready,
   output logic              cfg_err,
   output logic              q,
   output logic              tick,
   output logic              running,
   output logic [N-1:0]      div_active
`ifdef CLKDIV_CTRL_PCNT_EN
   ,
   output logic [PCNT_W-1:0] period_cnt
`endif
);

   localparam logic [N-1:0] DIV_RST = N'(DIV_DEFAULT);
   localparam logic [N-1:0] MIN_LIM = N'(MIN_DIV);

   state_t       state;
   logic [N-1:0] pend_div;
   logic [N-1:0] div_next;
   logic         accept;
   logic         legal_req;
   logic         core_clear;
   logic         wrap;

   assign accept     = cfg_valid && cfg_ready;
   assign legal_req  = (cfg_div >= MIN_LIM);
   assign core_clear = (state == STOP);

   // ---------------------------------------------------------------------------
   // Period counter. en low stops counting immediately, which also suppresses
   // the tick of a wrap that coincides with en dropping.
   // ---------------------------------------------------------------------------
   clkdiv_core #(
      .N (N)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .div   (div_active),
      .run   (en),
      .clear (core_clear),
      .q     (q),
      .tick  (tick),
      .wrap  (wrap)
   );

   // ---------------------------------------------------------------------------
   // Next divisor in force. Kept separate from the FSM so the optional period
   // counter can see a divisor change on the edge it happens.
   // ---------------------------------------------------------------------------
   always_comb begin
      div_next = div_active;
      case (state)
         STOP: begin
            if (accept && legal_req) begin
               div_next = cfg_div;
            end
         end
         RUN: begin
            // A legal request arriving together with en low is a STOP load.
            if (!en && accept && legal_req) begin
               div_next = cfg_div;
            end
         end
         PENDING: begin
            // Stopping applies the waiting divisor at once; otherwise it
            // waits for the wrap edge.
            if (!en || wrap) begin
               div_next = pend_div;
            end
         end
         default: div_next = div_active;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Controller FSM with registered handshake and status outputs.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= STOP;
         div_active <= DIV_RST;
         pend_div   <= '0;
         running    <= 1'b0;
         cfg_ready  <= 1'b1;
         cfg_err    <= 1'b0;
      end else begin
         div_active <= div_next;
         cfg_err    <= accept && !legal_req;
         case (state)
            STOP: begin
               cfg_ready <= 1'b1;
               if (en) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (!en) begin
                  state     <= STOP;
                  running   <= 1'b0;
                  cfg_ready <= 1'b1;
               end else if (accept && legal_req) begin
                  // Even when this is the wrap cycle, the new divisor waits
                  // for the following wrap: the PENDING state is only
                  // entered on this edge.
                  pend_div  <= cfg_div;
                  state     <= PENDING;
                  cfg_ready <= 1'b0;
               end
            end
            PENDING: begin
               if (!en) begin
                  state     <= STOP;
                  running   <= 1'b0;
                  cfg_ready <= 1'b1;
               end else if (wrap) begin
                  state     <= RUN;
                  cfg_ready <= 1'b1;
               end
            end
            default: begin
               state     <= STOP;
               running   <= 1'b0;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef CLKDIV_CTRL_PCNT_EN
   // ---------------------------------------------------------------------------
   // Tick counter; restarts whenever a new divisor comes into force so it
   // always reports periods of the current rate. Wraps naturally at 0xFFFF.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_cnt <= '0;
      end else if (div_next != div_active) begin
         period_cnt <= '0;
      end else if (tick) begin
         period_cnt <= period_cnt + PCNT_W'(1);
      end
   end
`endif

endmodule : clkdiv_ctrl

// File: tb/tb_clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_ctrl
// -----------------------------------------------------------------------------
// Directed bench for clkdiv_ctrl with N=8, DIV_DEFAULT=10, MIN_DIV=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that
// same point, so each observation reflects the registers of the edge just
// passed. Edge numbering Ek counts edges after en (or a request) was driven.
// -----------------------------------------------------------------------------
module tb_clkdiv_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         cfg_valid;
  logic [N-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         q;
  logic         tick;
  logic         running;
  logic [N-1:0] div_active;
`ifdef CLKDIV_CTRL_PCNT_EN
  logic [15:0]  period_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clkdiv_ctrl #(
    .N           (N),
    .DIV_DEFAULT (10),
    .MIN_DIV     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .q          (q),
    .tick       (tick),
    .running    (running),
    .div_active (div_active)
`ifdef CLKDIV_CTRL_PCNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Reset values while reset is held from time zero.
  task automatic test_reset();
    step();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL reset_q: got %b exp 0", q); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b exp 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b exp 0", running); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", cfg_err); end
    checks++; if (div_active !== 8'd10) begin errors++; $display("FAIL reset_div: got %0d exp 10", div_active); end
    reset = 1'b0;
  endtask

  // Default divisor 10: E1 is the first RUN cycle (count 0), ticks at E11, E21, E31.
  task automatic test_run();
    int c;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      c = (k - 1) % 10;
      checks++; if (tick !== ((k > 1) && (c == 0))) begin errors++; $display("FAIL run_tick E%0d: got %b exp %b", k, tick, (k > 1) && (c == 0)); end
      checks++; if (q !== (c >= 5)) begin errors++; $display("FAIL run_q E%0d: got %b exp %b", k, q, c >= 5); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running E%0d: got %b exp 1", k, running); end
    end
  endtask

  // Request 4 at count 3: current period finishes, then 4-cycle periods.
  task automatic test_reconfig();
    int c;
    do_reset();
    en = 1'b1;
    repeat (4) step();
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step(); // E5, count 4, request taken
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reconf_ready_low: got %b exp 0", cfg_ready); end
    checks++; if (div_active !== 8'd10) begin errors++; $display("FAIL reconf_div_hold: got %0d exp 10", div_active); end
    cfg_valid = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      step();
      checks++; if (q !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL reconf_old_period E%0d: got q=%b tick=%b exp q=1 tick=0", k, q, tick); end
    end
    step(); // E11 wrap
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL reconf_wrap_tick: got %b exp 1", tick); end
    checks++; if (div_active !== 8'd4) begin errors++; $display("FAIL reconf_div_new: got %0d exp 4", div_active); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reconf_ready_back: got %b exp 1", cfg_ready); end
    for (int k = 12; k <= 19; k++) begin
      step();
      c = (k - 11) % 4;
      checks++; if (q !== (c >= 2) || tick !== (c == 0)) begin errors++; $display("FAIL reconf_new_period E%0d: got q=%b tick=%b exp q=%b tick=%b", k, q, tick, c >= 2, c == 0); end
    end
  endtask

  // Divisor 1 is illegal: one-cycle error, rate unchanged.
  task automatic test_illegal();
    do_reset();
    en = 1'b1;
    step(); step();
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step(); // E3
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse: got %b exp 1", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b exp 1", cfg_ready); end
    cfg_valid = 1'b0;
    step(); // E4
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear: got %b exp 0", cfg_err); end
    for (int k = 5; k <= 25; k++) begin
      step();
      checks++; if (tick !== ((k == 11) || (k == 21))) begin errors++; $display("FAIL illegal_tick E%0d: got %b exp %b", k, tick, (k == 11) || (k == 21)); end
    end
    checks++; if (div_active !== 8'd10) begin errors++; $display("FAIL illegal_div: got %0d exp 10", div_active); end
  endtask

  // Load 5 while stopped, then run: period 5, q 2 low / 3 high.
  task automatic test_stop_load();
    int c;
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();
    checks++; if (div_active !== 8'd5) begin errors++; $display("FAIL stopload_div: got %0d exp 5", div_active); end
    checks++; if (cfg_ready !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL stopload_status: got ready=%b running=%b exp 1 0", cfg_ready, running); end
    cfg_valid = 1'b0; en = 1'b1;
    for (int j = 0; j <= 15; j++) begin
      step();
      c = j % 5;
      checks++; if (tick !== ((j > 0) && (c == 0))) begin errors++; $display("FAIL stopload_tick j%0d: got %b exp %b", j, tick, (j > 0) && (c == 0)); end
      checks++; if (q !== (c >= 2)) begin errors++; $display("FAIL stopload_q j%0d: got %b exp %b", j, q, c >= 2); end
    end
  endtask

  // en drops while a divisor of 6 is pending: applied at once on stop.
  task automatic test_pending_stop();
    do_reset();
    en = 1'b1;
    step(); // E1
    cfg_valid = 1'b1; cfg_div = 8'd6;
    step(); // E2
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pendstop_ready_low: got %b exp 0", cfg_ready); end
    cfg_valid = 1'b0;
    repeat (6) step(); // E8, count 7
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL pendstop_q_before: got %b exp 1", q); end
    en = 1'b0;
    step();
    checks++; if (running !== 1'b0 || q !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL pendstop_outputs: got running=%b q=%b tick=%b exp 0 0 0", running, q, tick); end
    checks++; if (div_active !== 8'd6) begin errors++; $display("FAIL pendstop_div: got %0d exp 6", div_active); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL pendstop_ready: got %b exp 1", cfg_ready); end
  endtask

  // Coincident events and the MIN_DIV boundary.
  task automatic test_simultaneous();
    do_reset();
    en = 1'b1;
    repeat (10) step(); // E10, count 9: next edge would wrap
    en = 1'b0;
    step();
    checks++; if (tick !== 1'b0 || q !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL simul_wrap_stop: got tick=%b q=%b running=%b exp 0 0 0", tick, q, running); end

    do_reset();
    en = 1'b1;
    repeat (3) step();
    en = 1'b0; cfg_valid = 1'b1; cfg_div = 8'd7;
    step();
    checks++; if (div_active !== 8'd7 || running !== 1'b0) begin errors++; $display("FAIL simul_stop_load: got div=%0d running=%b exp 7 0", div_active, running); end
    cfg_div = 8'd0;
    step();
    checks++; if (cfg_err !== 1'b1 || div_active !== 8'd7) begin errors++; $display("FAIL simul_zero_div: got err=%b div=%0d exp 1 7", cfg_err, div_active); end
    cfg_div = 8'd2;
    step();
    checks++; if (cfg_err !== 1'b0 || div_active !== 8'd2) begin errors++; $display("FAIL simul_min_div: got err=%b div=%0d exp 0 2", cfg_err, div_active); end
    cfg_valid = 1'b0; en = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      step();
      checks++; if (q !== ((j % 2) == 1) || tick !== ((j > 0) && ((j % 2) == 0))) begin errors++; $display("FAIL simul_div2 j%0d: got q=%b tick=%b exp q=%b tick=%b", j, q, tick, (j % 2) == 1, (j > 0) && ((j % 2) == 0)); end
    end
  endtask

  // Request taken on the wrap cycle applies at the following wrap.
  task automatic test_back_to_back();
    do_reset();
    en = 1'b1;
    repeat (10) step(); // E10, count 9
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step(); // E11 wrap
    checks++; if (tick !== 1'b1 || div_active !== 8'd10 || cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_first_wrap: got tick=%b div=%0d ready=%b exp 1 10 0", tick, div_active, cfg_ready); end
    cfg_valid = 1'b0;
    for (int k = 12; k <= 20; k++) begin
      step();
      checks++; if (tick !== 1'b0 || div_active !== 8'd10) begin errors++; $display("FAIL b2b_hold E%0d: got tick=%b div=%0d exp 0 10", k, tick, div_active); end
    end
    step(); // E21
    checks++; if (tick !== 1'b1 || div_active !== 8'd4 || cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_apply: got tick=%b div=%0d ready=%b exp 1 4 1", tick, div_active, cfg_ready); end
    repeat (4) step(); // E25
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL b2b_short_period: got %b exp 1", tick); end
  endtask

  // Asynchronous reset mid-cycle while a divisor is pending.
  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    repeat (5) step();
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step(); // E6, pending
    cfg_valid = 1'b0;
    step(); step(); // E8, count 7
    checks++; if (q !== 1'b1 || running !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL areset_before: got q=%b running=%b ready=%b exp 1 1 0", q, running, cfg_ready); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (q !== 1'b0 || tick !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL areset_outputs: got q=%b tick=%b running=%b exp 0 0 0", q, tick, running); end
    checks++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || div_active !== 8'd10) begin errors++; $display("FAIL areset_cfg: got ready=%b err=%b div=%0d exp 1 0 10", cfg_ready, cfg_err, div_active); end
    en = 1'b0;
    step(); step();
    reset = 1'b0; en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      checks++; if (tick !== (k == 11)) begin errors++; $display("FAIL areset_resume E%0d: got %b exp %b", k, tick, k == 11); end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    test_reset();
    test_run();
    test_reconfig();
    test_illegal();
    test_stop_load();
    test_pending_stop();
    test_simultaneous();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_clkdiv_ctrl

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Runtime-configurable clock-divider controller. It generates the divided square wave `q` and a one-cycle `tick` strobe from the system clock.
- The divisor is loaded through a valid/ready configuration handshake.
- A new divisor takes effect only at a period boundary, so `q` never glitches or produces a short period.
- It sits between the system clock and the display/counter logic, replacing fixed-divisor dividers wherever software or FSMs must retune the rate.

Parameters:
- N, 26, counter and divisor width in bits.
- DIV_DEFAULT, 50000000, divisor after reset (1 Hz from 50 MHz).
- MIN_DIV, 2, smallest legal divisor; smaller requests are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable (level).
- cfg_valid  in  1  a new divisor is presented.
- cfg_div  in  N  requested divisor.
- cfg_ready  out  1  controller can accept a divisor.
- cfg_err  out  1  one-cycle pulse: last accepted request was illegal.
- q  out  1  divided square wave.
- tick  out  1  one-cycle strobe per completed period.
- running  out  1  high in RUN or PENDING.
- div_active  out  N  divisor currently in force.

Behaviour:
- Clock and reset: one clock domain. `reset` is asynchronous, active-high.
- Reset values: state=STOP, cnt=0, div_active=DIV_DEFAULT, pend_div=0, q=0, tick=0, running=0, cfg_ready=1, cfg_err=0.
- Registered outputs: all outputs are registered.
- States:
  - STOP: counter held at 0, q=0.
  - RUN: counting with div_active.
  - PENDING: counting, with a new divisor waiting in pend_div.
- STOP -> RUN: when en=1. cnt=0 on the first RUN cycle. The first tick occurs div_active cycles later.
- Counting (RUN/PENDING):
  - cnt increments each cycle.
  - When cnt==div_active-1, the next cnt is 0 (wrap).
  - tick=1 for exactly the one cycle following each wrap edge (the cycle in which cnt==0 after a wrap).
  - Period is exactly div_active cycles.
- q tracks the new cnt in the same cycle: q=1 iff cnt >= (div_active>>1).
  - Even D: D/2 cycles low, then D/2 high.
  - Odd D: floor(D/2) cycles low, then ceil(D/2) high.
- Handshake:
  - A request is accepted on a cycle with cfg_valid && cfg_ready.
  - While cfg_ready=0, cfg_valid is ignored; the requester holds its request.
- Illegal request (cfg_div < MIN_DIV):
  - Request is consumed.
  - cfg_err=1 on the next cycle, for one cycle.
  - No change to state, div_active or cnt.
- Legal request in STOP: div_active=cfg_div next cycle; cfg_ready stays 1.
- Legal request in RUN:
  - pend_div=cfg_div, state -> PENDING, cfg_ready=0.
  - At the next wrap: div_active=pend_div, cnt=0, state -> RUN, cfg_ready=1 on that same edge.
  - A request accepted on the wrap cycle itself is applied at the following wrap, not the current one.
- en=0 while in RUN or PENDING:
  - STOP next cycle: cnt=0, q=0, tick=0.
  - Any pending divisor is applied immediately to div_active; cfg_ready=1.
- Simultaneous events:
  - en deassert plus a legal request on the same cycle: handled as a STOP load; div_active=cfg_div.
  - en deassert and wrap on the same cycle: no tick is emitted.
- Reset mid-operation: all registers return to reset values immediately; the pending divisor is discarded.
- Arithmetic: the wrap compare uses div_active-1 at N bits. MIN_DIV>=2 guarantees no underflow.

Optional Feature:
- Macro: CLKDIV_CTRL_PCNT_EN.
- Defined:
  - Adds output port `period_cnt`, 16 bits, counting ticks.
  - Increments on each tick; wraps from 0xFFFF to 0.
  - Cleared on reset and whenever div_active changes.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package clkdiv_pkg holds:
  - State encoding: STOP, RUN, PENDING.
  - MIN_DIV and DIV_DEFAULT default constants.
  - Width of period_cnt (16).
- Sub-module clkdiv_core: counter, wrap detect, q and tick generation, with inputs div, run, clear.
- clkdiv_ctrl holds the FSM, handshake and pend_div register.

Test Plan:
All scenarios use N=8 and DIV_DEFAULT=10.
1. Reset, then en=1 -> first tick 10 cycles after RUN entry, then every 10 cycles; q shows 5 cycles low, 5 high; running=1.
2. While running at cnt=3, cfg_div=4 -> cfg_ready=0. The current period completes (cnt 4..9). Next period is 4 cycles with q 2 low/2 high; div_active=4 and cfg_ready=1 at the wrap.
3. cfg_div=1 -> cfg_err pulses for one cycle; div_active stays 10; tick spacing unchanged.
4. In STOP, cfg_div=5, then en=1 -> ticks every 5 cycles; q 2 low/3 high.
5. In PENDING with pend_div=6, en drops -> STOP next cycle; div_active=6, q=0, cfg_ready=1, no tick.
6. Async reset asserted mid-cycle at cnt=7 -> all outputs take reset values before the next clk edge; div_active=10.
